branch_history_queue: RTL and testbench
=======================================

BRANCH_HISTORY_QUEUE -- requirements
Module: branch_history_queue

Interface
REQ-001 The block SHALL have parameter FEATURES, default 32, which is the global history length and the feature-vector width.
REQ-002 The block SHALL have parameter DEPTH, default 8, which is the number of in-flight branch entries (power of 2, at least 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port fetch_valid, input, 1 bit: a predicted branch is presented this cycle.
REQ-006 The block SHALL have port fetch_pc, input, 32 bits: PC of the fetched branch.
REQ-007 The block SHALL have port fetch_pred_taken, input, 1 bit: the predictor's direction for that branch.
REQ-008 The block SHALL have port fetch_ready, output, 1 bit: the queue can accept an entry; combinational, equal to (count != DEPTH).
REQ-009 The block SHALL have port predict_features, output, FEATURES bits: the speculative global history, driven directly from a register.
REQ-010 The block SHALL have port resolve_valid, input, 1 bit: the oldest in-flight branch resolves this cycle (resolution is in order).
REQ-011 The block SHALL have port resolve_taken, input, 1 bit: the actual direction of the oldest branch.
REQ-012 The block SHALL have port flush, input, 1 bit: discard all in-flight branches (exception or redirect).
REQ-013 The block SHALL have port train_en, output, 1 bit: registered one-cycle training pulse.
REQ-014 The block SHALL have port train_pc, output, 32 bits: registered PC of the trained branch.
REQ-015 The block SHALL have port train_features, output, FEATURES bits: registered history used at that branch's prediction.
REQ-016 The block SHALL have port actual_taken, output, 1 bit: registered actual direction.
REQ-017 The block SHALL have port mispredict, output, 1 bit: registered one-cycle pulse on a direction mismatch.
REQ-018 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: the number of valid entries.
REQ-019 The block SHALL have port underflow_err, output, 1 bit: sticky flag set when a resolve arrives while the queue is empty.

Function
REQ-020 Fetch SHALL be accepted only when fetch_valid=1, fetch_ready=1, flush=0 and no mispredict recovery occurs in the same cycle.
REQ-021 On an accepted fetch, the block SHALL write {fetch_pc, spec_ghr (the value before update), fetch_pred_taken} at the tail, advance the tail by one modulo DEPTH, and set spec_ghr <= {spec_ghr[FEATURES-2:0], fetch_pred_taken}.
REQ-022 The block SHALL perform a resolve only when resolve_valid=1, count!=0 and flush=0; the head entry is the one resolved.
REQ-023 On a resolve, the block SHALL pop the head (head+1 mod DEPTH) and set committed_ghr <= {committed_ghr[FEATURES-2:0], resolve_taken}.
REQ-024 On the cycle after a resolve, train_en=1, train_pc=entry.pc, train_features=entry.ghr and actual_taken=resolve_taken; in all other cycles train_en=0 and the train data outputs hold their previous values.
REQ-025 If resolve_taken != entry.pred_taken, the block SHALL on the same edge empty the queue (count=0, head=tail), set spec_ghr to the new committed_ghr value, ignore any same-cycle fetch, and assert mispredict=1 on the next cycle together with train_en.
REQ-026 A correct resolve and an accepted fetch in the same cycle SHALL both take effect, with count unchanged; at full, fetch_ready=0, so only the pop occurs.
REQ-027 A resolve_valid arriving when count=0 SHALL be ignored (no train_en) and SHALL set underflow_err=1, which stays set until rst; a same-cycle fetch into the empty queue is still accepted.
REQ-028 A fetch_valid arriving when full SHALL be dropped with no state change.
REQ-029 flush=1 SHALL empty the queue, set spec_ghr <= committed_ghr, ignore same-cycle fetch and resolve, and produce no train_en or mispredict.
REQ-030 Priority SHALL be: rst > flush > mispredict recovery > resolve/fetch.
REQ-031 Head and tail pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.

Reset
REQ-032 On rst assertion, asynchronously: spec_ghr=0, committed_ghr=0, head=tail=0, count=0, fetch_ready=1, train_en=0, train_pc=0, train_features=0, actual_taken=0, mispredict=0, underflow_err=0; entry contents need not be cleared.
REQ-033 Reset asserted mid-operation SHALL discard all entries, with no train_en after release.

Verification
REQ-034 Reset, then fetch PCs 0x100 (T), 0x104 (N), 0x108 (T) on consecutive cycles -> count=3, predict_features=0x00000005.
REQ-035 Resolve taken for the head (0x100, predicted T) -> the next cycle has train_en=1, train_pc=0x100, train_features=0, actual_taken=1, mispredict=0; count=2.
REQ-036 Then resolve taken for 0x104 (predicted N), with a same-cycle fetch of 0x10C -> mispredict=1, train_pc=0x104, train_features=0x1, count=0, predict_features=0x3, and 0x10C not queued.
REQ-037 Eight fetches from empty -> fetch_ready=0; a ninth fetch is dropped; then resolve (correct) plus fetch in the same cycle -> count=7, and the dropped PC never appears on train_pc.
REQ-038 Three fetches, then flush=1 with resolve_valid=1 -> count=0, no train_en, predict_features equals committed history; a following resolve_valid -> underflow_err=1, which persists until rst.

Source files
------------

// File: rtl/branch_history_queue.sv
// branch_history_queue
//   Holds in-flight predicted branches between fetch and in-order resolve.
//   Each entry is stored at fetch. It holds the branch PC, the speculative
//   global history seen at prediction, and the predicted direction. When the
//   oldest branch resolves, the block emits a registered training record.
//   The committed history tracks resolved outcomes only. It is the restore
//   point for the speculative history on a mispredict or a flush.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   fetch_valid/ready   : push handshake; fetch_pc, fetch_pred_taken payload
//   predict_features    : speculative global history (register output)
//   resolve_valid       : oldest branch resolves; resolve_taken = outcome
//   flush               : discard all in-flight branches
//   train_en            : one-cycle pulse; train_pc, train_features, actual_taken
//   mispredict          : one-cycle pulse alongside train_en on a wrong guess
//   count               : number of valid entries
//   underflow_err       : sticky, a resolve arrived while the queue was empty
//
// Handshake: a fetch transfers on a cycle where fetch_valid && fetch_ready,
// unless flush or mispredict recovery happens on that cycle. fetch_ready
// depends only on count, never on fetch_valid. resolve_valid has no ready
// signal. A resolve against an empty queue is dropped and flagged.
module branch_history_queue #(
    parameter int FEATURES = 32,
    parameter int DEPTH    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_valid,
    input  logic [31:0]                fetch_pc,
    input  logic                       fetch_pred_taken,
    output logic                       fetch_ready,
    output logic [FEATURES-1:0]        predict_features,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    input  logic                       flush,
    output logic                       train_en,
    output logic [31:0]                train_pc,
    output logic [FEATURES-1:0]        train_features,
    output logic                       actual_taken,
    output logic                       mispredict,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       underflow_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]         pc_mem   [DEPTH];
    logic [FEATURES-1:0] ghr_mem  [DEPTH];
    logic                pred_mem [DEPTH];

    logic [PTR_W-1:0]    head, tail;
    logic [FEATURES-1:0] spec_ghr, committed_ghr;

    logic                resolve_fire, fetch_fire, recover;
    logic [FEATURES-1:0] committed_next;

    assign fetch_ready      = (count != CNT_W'(DEPTH));
    assign predict_features = spec_ghr;

    always_comb begin
        resolve_fire   = resolve_valid && (count != '0) && !flush;
        // A wrong direction on the head restarts fetch from the committed state.
        recover        = resolve_fire && (resolve_taken != pred_mem[head]);
        fetch_fire     = fetch_valid && fetch_ready && !flush && !recover;
        committed_next = {committed_ghr[FEATURES-2:0], resolve_taken};
    end

    // Entry payload is not reset; stale slots are never read while count is 0.
    always_ff @(posedge clk) begin
        if (fetch_fire) begin
            pc_mem[tail]   <= fetch_pc;
            ghr_mem[tail]  <= spec_ghr;
            pred_mem[tail] <= fetch_pred_taken;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            spec_ghr       <= '0;
            committed_ghr  <= '0;
            train_en       <= 1'b0;
            train_pc       <= '0;
            train_features <= '0;
            actual_taken   <= 1'b0;
            mispredict     <= 1'b0;
            underflow_err  <= 1'b0;
        end else begin
            train_en   <= 1'b0;
            mispredict <= 1'b0;

            if (resolve_valid && (count == '0) && !flush)
                underflow_err <= 1'b1;

            if (resolve_fire) begin
                train_en       <= 1'b1;
                train_pc       <= pc_mem[head];
                train_features <= ghr_mem[head];
                actual_taken   <= resolve_taken;
                committed_ghr  <= committed_next;
            end

            if (flush) begin
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                spec_ghr <= committed_ghr;
            end else if (recover) begin
                head       <= '0;
                tail       <= '0;
                count      <= '0;
                spec_ghr   <= committed_next;
                mispredict <= 1'b1;
            end else begin
                if (resolve_fire)
                    head <= head + PTR_W'(1);
                if (fetch_fire) begin
                    tail     <= tail + PTR_W'(1);
                    spec_ghr <= {spec_ghr[FEATURES-2:0], fetch_pred_taken};
                end
                case ({resolve_fire, fetch_fire})
                    2'b10:   count <= count - CNT_W'(1);
                    2'b01:   count <= count + CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_branch_history_queue.sv
module tb_branch_history_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid, fetch_pred_taken, fetch_ready;
    logic [31:0] fetch_pc;
    logic [31:0] predict_features;
    logic        resolve_valid, resolve_taken, flush;
    logic        train_en, actual_taken, mispredict, underflow_err;
    logic [31:0] train_pc;
    logic [31:0] train_features;
    logic [3:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    branch_history_queue #(.FEATURES(32), .DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .fetch_pred_taken(fetch_pred_taken), .fetch_ready(fetch_ready),
        .predict_features(predict_features),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .flush(flush),
        .train_en(train_en), .train_pc(train_pc),
        .train_features(train_features), .actual_taken(actual_taken),
        .mispredict(mispredict), .count(count), .underflow_err(underflow_err)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fetch(input logic v, input logic [31:0] pc, input logic t);
        fetch_valid      = v;
        fetch_pc         = pc;
        fetch_pred_taken = t;
    endtask

    task automatic set_resolve(input logic v, input logic t);
        resolve_valid = v;
        resolve_taken = t;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        set_fetch(0, 0, 0);
        set_resolve(0, 0);
        step();
        step();
        check("rst_count", count, 0);
        check("rst_ready", fetch_ready, 1);
        check("rst_pf", predict_features, 0);
        check("rst_train_en", train_en, 0);
        check("rst_train_pc", train_pc, 0);
        check("rst_misp", mispredict, 0);
        check("rst_uflow", underflow_err, 0);
        rst = 1'b0;

        // three fetches: T, N, T -> history 0b101
        set_fetch(1, 32'h100, 1); step();
        set_fetch(1, 32'h104, 0); step();
        set_fetch(1, 32'h108, 1); step();
        set_fetch(0, 0, 0);
        check("f3_count", count, 3);
        check("f3_pf", predict_features, 32'h5);

        // correct resolve of 0x100
        set_resolve(1, 1); step();
        set_resolve(0, 0);
        check("r1_train_en", train_en, 1);
        check("r1_train_pc", train_pc, 32'h100);
        check("r1_train_feat", train_features, 0);
        check("r1_actual", actual_taken, 1);
        check("r1_misp", mispredict, 0);
        check("r1_count", count, 2);

        // mispredict on 0x104 with a same-cycle fetch of 0x10C
        set_resolve(1, 1);
        set_fetch(1, 32'h10C, 1);
        step();
        set_resolve(0, 0);
        set_fetch(0, 0, 0);
        check("m_misp", mispredict, 1);
        check("m_train_en", train_en, 1);
        check("m_train_pc", train_pc, 32'h104);
        check("m_train_feat", train_features, 32'h1);
        check("m_count", count, 0);
        check("m_pf", predict_features, 32'h3);
        step();
        check("m_misp_pulse", mispredict, 0);
        check("m_train_pulse", train_en, 0);
        check("m_no_10c", count, 0);
        check("m_hold_pc", train_pc, 32'h104);

        // fill eight, predicted not-taken; history 0x3 shifts left by 8
        for (int i = 0; i < 8; i++) begin
            set_fetch(1, 32'h200 + 32'(4 * i), 0);
            step();
        end
        check("full_count", count, 8);
        check("full_ready", fetch_ready, 0);
        check("full_pf", predict_features, 32'h300);
        set_fetch(1, 32'h300, 1); step();
        check("drop_count", count, 8);
        check("drop_pf", predict_features, 32'h300);
        // correct resolve + fetch at full: only the pop happens
        set_resolve(1, 0);
        set_fetch(1, 32'h240, 1);
        step();
        set_fetch(0, 0, 0);
        check("full_pop_count", count, 7);
        check("full_pop_pc", train_pc, 32'h200);
        check("full_pop_feat", train_features, 32'h3);
        // drain the remaining seven in order
        for (int i = 1; i < 8; i++) begin
            step();
            check("drain_en", train_en, 1);
            check("drain_pc", train_pc, 32'h200 + 32'(4 * i));
            check("drain_feat", train_features, 32'h3 << i);
            check("drain_misp", mispredict, 0);
        end
        set_resolve(0, 0);
        check("drain_count", count, 0);
        step();
        check("drain_idle", train_en, 0);
        check("drain_uflow", underflow_err, 0);

        // simultaneous correct resolve and fetch keeps count
        set_fetch(1, 32'h400, 1); step();
        set_resolve(1, 1);
        set_fetch(1, 32'h404, 1);
        step();
        set_fetch(0, 0, 0);
        check("sim_count", count, 1);
        check("sim_pc", train_pc, 32'h400);
        check("sim_feat", train_features, 32'h300);
        check("sim_pf", predict_features, 32'hC03);
        step();
        set_resolve(0, 0);
        check("sim2_pc", train_pc, 32'h404);
        check("sim2_feat", train_features, 32'h601);
        check("sim2_count", count, 0);

        // flush with three in flight and a same-cycle resolve
        set_fetch(1, 32'h500, 0); step();
        set_fetch(1, 32'h504, 0); step();
        set_fetch(1, 32'h508, 0); step();
        set_fetch(0, 0, 0);
        check("pf_count", count, 3);
        check("pf_spec", predict_features, 32'h6018);
        flush = 1'b1;
        set_resolve(1, 1);
        step();
        flush = 1'b0;
        check("fl_count", count, 0);
        check("fl_train_en", train_en, 0);
        check("fl_misp", mispredict, 0);
        check("fl_pf", predict_features, 32'hC03);
        // resolve on empty flags underflow; fetch still accepted
        set_fetch(1, 32'h600, 0);
        step();
        set_resolve(0, 0);
        set_fetch(0, 0, 0);
        check("uf_flag", underflow_err, 1);
        check("uf_train_en", train_en, 0);
        check("uf_count", count, 1);
        check("uf_pf", predict_features, 32'h1806);
        step();
        step();
        check("uf_sticky", underflow_err, 1);

        // asynchronous reset mid-operation
        #2 rst = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_uflow", underflow_err, 0);
        check("arst_pf", predict_features, 0);
        step();
        rst = 1'b0;
        step();
        check("arst_train_en", train_en, 0);
        check("arst_count2", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
